// File: rtl/trigger_capture_ctrl_if.sv
// Bus between the ADC sample stream / config registers and the capture controller.
// The slave side is the controller; the master side drives samples and config.
interface trigger_capture_ctrl_if #(
  parameter int DATA_SIZE = 8,
  parameter int CNT_WIDTH = 10
);
  logic                 sample_valid_i;
  logic [DATA_SIZE-1:0] sample_data_i;
  logic                 arm_i;
  logic                 abort_i;
  logic [1:0]           mode_i;
  logic [DATA_SIZE-1:0] level_i;
  logic [DATA_SIZE-1:0] hyst_i;
  logic [CNT_WIDTH-1:0] pre_count_i;
  logic [CNT_WIDTH-1:0] post_count_i;
  logic                 fifo_empty_i;
  logic                 w_en_o;
  logic                 drop_o;
  logic [DATA_SIZE-1:0] data_o;
  logic                 trigger_o;
  logic                 busy_o;
  logic                 done_o;

  modport slave (
    input  sample_valid_i, sample_data_i, arm_i, abort_i, mode_i, level_i, hyst_i,
           pre_count_i, post_count_i, fifo_empty_i,
    output w_en_o, drop_o, data_o, trigger_o, busy_o, done_o
  );

  modport master (
    output sample_valid_i, sample_data_i, arm_i, abort_i, mode_i, level_i, hyst_i,
           pre_count_i, post_count_i, fifo_empty_i,
    input  w_en_o, drop_o, data_o, trigger_o, busy_o, done_o
  );
endinterface

// File: rtl/trigger_capture_ctrl.sv
// Trigger/capture controller: pre-trigger sliding window, edge/auto trigger with
// hysteresis, post-trigger length; all outputs registered.
module trigger_capture_ctrl #(
  parameter int DATA_SIZE = 8,
  parameter int CNT_WIDTH = 10
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  trigger_capture_ctrl_if.slave  bus
);
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_ARMED, S_POST, S_DONE} state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_e               state_q, state_d;
  logic [1:0]           mode_q, mode_d;
  logic [DATA_SIZE-1:0] level_q, level_d, lo_q, lo_d, hi_q, hi_d;
  logic [CNT_WIDTH-1:0] pre_q, pre_d, post_q, post_d;
  logic [CNT_WIDTH-1:0] pre_cnt_q, pre_cnt_d, post_cnt_q, post_cnt_d;
  logic                 rise_ok_q, rise_ok_d, fall_ok_q, fall_ok_d;
  logic                 w_en_q, w_en_d, drop_q, drop_d, trig_q, trig_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic [DATA_SIZE-1:0] data_q, data_d;

  // Saturating thresholds, computed from the live inputs and latched on arm
  logic [DATA_SIZE:0]   hi_sum;
  logic [DATA_SIZE-1:0] lo_in, hi_in;
  assign hi_sum = {1'b0, bus.level_i} + {1'b0, bus.hyst_i};
  assign hi_in  = hi_sum[DATA_SIZE] ? '1 : hi_sum[DATA_SIZE-1:0];
  assign lo_in  = (bus.level_i > bus.hyst_i) ? (bus.level_i - bus.hyst_i) : '0;

  logic [DATA_SIZE-1:0] smp;
  logic                 arm_ok, rise_hit, fall_hit, trig_hit;
  assign smp      = bus.sample_data_i;
  assign arm_ok   = bus.arm_i && bus.fifo_empty_i && !bus.abort_i;
  // Flags are the registered ones, so the sample that sets a flag cannot fire
  assign rise_hit = rise_ok_q && (smp >= level_q);
  assign fall_hit = fall_ok_q && (smp <= level_q);

  always_comb begin
    trig_hit = 1'b0;
    unique case (mode_q)
      2'b00:   trig_hit = rise_hit;
      2'b01:   trig_hit = fall_hit;
      2'b10:   trig_hit = rise_hit || fall_hit;
      default: trig_hit = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    level_d    = level_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    pre_d      = pre_q;
    post_d     = post_q;
    pre_cnt_d  = pre_cnt_q;
    post_cnt_d = post_cnt_q;
    rise_ok_d  = rise_ok_q;
    fall_ok_d  = fall_ok_q;
    data_d     = data_q;
    w_en_d     = 1'b0;
    drop_d     = 1'b0;
    trig_d     = 1'b0;

    if ((state_q == S_FILL || state_q == S_ARMED) && bus.sample_valid_i && !bus.abort_i) begin
      if (smp < lo_q) rise_ok_d = 1'b1;
      if (smp > hi_q) fall_ok_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (arm_ok) begin
          mode_d     = bus.mode_i;
          level_d    = bus.level_i;
          lo_d       = lo_in;
          hi_d       = hi_in;
          pre_d      = bus.pre_count_i;
          post_d     = (bus.post_count_i == '0) ? CNT_ONE : bus.post_count_i;
          pre_cnt_d  = '0;
          post_cnt_d = '0;
          rise_ok_d  = 1'b0;
          fall_ok_d  = 1'b0;
          state_d    = (bus.pre_count_i == '0) ? S_ARMED : S_FILL;
        end
      end
      S_FILL: begin
        if (bus.abort_i) state_d = S_IDLE;
        else if (bus.sample_valid_i) begin
          w_en_d    = 1'b1;
          data_d    = smp;
          pre_cnt_d = pre_cnt_q + CNT_ONE;
          if (pre_cnt_d == pre_q) state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (bus.abort_i) state_d = S_IDLE;
        else if (bus.sample_valid_i) begin
          data_d = smp;
          if (trig_hit) begin
            w_en_d     = 1'b1;
            trig_d     = 1'b1;
            post_cnt_d = CNT_ONE;
            state_d    = (post_q == CNT_ONE) ? S_DONE : S_POST;
          end else if (pre_q != '0) begin
            // Keep the pre-trigger window at pre_count entries
            w_en_d = 1'b1;
            drop_d = 1'b1;
          end
        end
      end
      S_POST: begin
        if (bus.abort_i) state_d = S_IDLE;
        else if (bus.sample_valid_i) begin
          w_en_d     = 1'b1;
          data_d     = smp;
          post_cnt_d = post_cnt_q + CNT_ONE;
          if (post_cnt_d == post_q) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_FILL) || (state_d == S_ARMED) || (state_d == S_POST);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      mode_q     <= '0;
      level_q    <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      pre_q      <= '0;
      post_q     <= '0;
      pre_cnt_q  <= '0;
      post_cnt_q <= '0;
      rise_ok_q  <= 1'b0;
      fall_ok_q  <= 1'b0;
      data_q     <= '0;
      w_en_q     <= 1'b0;
      drop_q     <= 1'b0;
      trig_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      level_q    <= level_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      pre_q      <= pre_d;
      post_q     <= post_d;
      pre_cnt_q  <= pre_cnt_d;
      post_cnt_q <= post_cnt_d;
      rise_ok_q  <= rise_ok_d;
      fall_ok_q  <= fall_ok_d;
      data_q     <= data_d;
      w_en_q     <= w_en_d;
      drop_q     <= drop_d;
      trig_q     <= trig_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.w_en_o    = w_en_q;
  assign bus.drop_o    = drop_q;
  assign bus.data_o    = data_q;
  assign bus.trigger_o = trig_q;
  assign bus.busy_o    = busy_q;
  assign bus.done_o    = done_q;
endmodule

// File: tb/tb_trigger_capture_ctrl.sv
// Scoreboard bench for trigger_capture_ctrl: expected writes are queued as samples
// are driven and popped by a monitor whenever w_en_o is seen.
module tb_trigger_capture_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  trigger_capture_ctrl_if #(.DATA_SIZE(8), .CNT_WIDTH(10)) bus ();

  trigger_capture_ctrl #(.DATA_SIZE(8), .CNT_WIDTH(10)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] d;
    logic       drop;
    logic       trig;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Monitor: every write must match the head of the queue; no stray drop/trigger
  always @(negedge clk) begin
    checks++;
    if (bus.w_en_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got data=%h drop=%b trig=%b, expected no write",
                 bus.data_o, bus.drop_o, bus.trigger_o);
      end else begin
        mon_e = exp_q.pop_front();
        if ({bus.data_o, bus.drop_o, bus.trigger_o} !== {mon_e.d, mon_e.drop, mon_e.trig}) begin
          errors++;
          $display("FAIL write got data=%h drop=%b trig=%b, expected data=%h drop=%b trig=%b",
                   bus.data_o, bus.drop_o, bus.trigger_o, mon_e.d, mon_e.drop, mon_e.trig);
        end
      end
    end else if (bus.drop_o === 1'b1 || bus.trigger_o === 1'b1) begin
      errors++;
      $display("FAIL strobe_without_write got drop=%b trig=%b, expected 0 0",
               bus.drop_o, bus.trigger_o);
    end
  end

  task automatic step();
    @(negedge clk);
    bus.sample_valid_i = 1'b0;
    bus.arm_i          = 1'b0;
    bus.abort_i        = 1'b0;
  endtask

  task automatic arm(input logic [1:0] m, input logic [7:0] lvl, input logic [7:0] hy,
                     input logic [9:0] pre, input logic [9:0] post);
    @(negedge clk);
    bus.mode_i         = m;
    bus.level_i        = lvl;
    bus.hyst_i         = hy;
    bus.pre_count_i    = pre;
    bus.post_count_i   = post;
    bus.arm_i          = 1'b1;
    bus.abort_i        = 1'b0;
    bus.sample_valid_i = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input bit wr, input bit drop, input bit trig);
    exp_t e;
    @(negedge clk);
    bus.arm_i          = 1'b0;
    bus.abort_i        = 1'b0;
    bus.sample_valid_i = 1'b1;
    bus.sample_data_i  = d;
    if (wr) begin
      e.d = d; e.drop = drop; e.trig = trig;
      exp_q.push_back(e);
    end
  endtask

  task automatic drain(input string name);
    step();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending got %0d writes outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.w_en_o, bus.drop_o, bus.trigger_o, bus.busy_o, bus.done_o, bus.data_o} !== 13'h0) begin
      errors++;
      $display("FAIL reset_outputs got w=%b d=%b t=%b b=%b dn=%b data=%h, expected all 0",
               bus.w_en_o, bus.drop_o, bus.trigger_o, bus.busy_o, bus.done_o, bus.data_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_rising();
    arm(2'b00, 8'h80, 8'h00, 10'd2, 10'd3);
    step();
    checks++;
    if ({bus.busy_o, bus.done_o} !== 2'b10) begin
      errors++;
      $display("FAIL rising_armed got busy=%b done=%b, expected 1 0", bus.busy_o, bus.done_o);
    end
    // Live config changes must not affect the running capture
    bus.level_i = 8'hFF;
    bus.mode_i  = 2'b01;
    send(8'h10, 1, 0, 0);
    send(8'h20, 1, 0, 0);
    send(8'h30, 1, 1, 0);
    send(8'h90, 1, 0, 1);
    send(8'hA0, 1, 0, 0);
    send(8'hB0, 1, 0, 0);
    send(8'hC0, 0, 0, 0);
    checks++;
    if ({bus.busy_o, bus.done_o} !== 2'b01) begin
      errors++;
      $display("FAIL rising_done got busy=%b done=%b, expected 0 1", bus.busy_o, bus.done_o);
    end
    drain("rising");
  endtask

  task automatic test_hysteresis();
    arm(2'b00, 8'h80, 8'h10, 10'd0, 10'd1);
    send(8'h7A, 0, 0, 0);
    send(8'h82, 0, 0, 0);
    send(8'h7A, 0, 0, 0);
    send(8'h82, 0, 0, 0);
    send(8'h6F, 0, 0, 0);
    send(8'h85, 1, 0, 1);
    step();
    checks++;
    if (bus.done_o !== 1'b1) begin
      errors++;
      $display("FAIL hyst_done got %b, expected 1", bus.done_o);
    end
    drain("hyst");
  endtask

  task automatic test_falling_either();
    arm(2'b01, 8'h40, 8'h00, 10'd0, 10'd1);
    step();
    checks++;
    if ({bus.busy_o, bus.done_o} !== 2'b10) begin
      errors++;
      $display("FAIL rearm_clears_done got busy=%b done=%b, expected 1 0", bus.busy_o, bus.done_o);
    end
    send(8'h50, 0, 0, 0);
    send(8'h30, 1, 0, 1);
    drain("falling");
    arm(2'b10, 8'h40, 8'h00, 10'd0, 10'd1);
    send(8'h20, 0, 0, 0);
    send(8'h50, 1, 0, 1);
    step();
    checks++;
    if (bus.done_o !== 1'b1) begin
      errors++;
      $display("FAIL either_done got %b, expected 1", bus.done_o);
    end
    drain("either");
  endtask

  task automatic test_auto();
    arm(2'b11, 8'h00, 8'h00, 10'd0, 10'd0);
    send(8'h55, 1, 0, 1);
    send(8'h66, 0, 0, 0);
    checks++;
    if ({bus.w_en_o, bus.trigger_o, bus.done_o} !== 3'b111) begin
      errors++;
      $display("FAIL auto_done got w=%b t=%b done=%b, expected 1 1 1",
               bus.w_en_o, bus.trigger_o, bus.done_o);
    end
    drain("auto");
  endtask

  task automatic test_arm_blocked();
    bus.fifo_empty_i = 1'b0;
    arm(2'b11, 8'h80, 8'h00, 10'd0, 10'd1);
    step();
    checks++;
    if ({bus.busy_o, bus.done_o} !== 2'b01) begin
      errors++;
      $display("FAIL arm_blocked got busy=%b done=%b, expected 0 1", bus.busy_o, bus.done_o);
    end
    send(8'h11, 0, 0, 0);
    bus.fifo_empty_i = 1'b1;
    drain("arm_blocked");
  endtask

  task automatic test_abort();
    arm(2'b11, 8'h00, 8'h00, 10'd0, 10'd4);
    send(8'h42, 1, 0, 1);
    @(negedge clk);
    bus.abort_i        = 1'b1;
    bus.sample_valid_i = 1'b1;
    bus.sample_data_i  = 8'h43;
    step();
    checks++;
    if ({bus.w_en_o, bus.busy_o, bus.done_o} !== 3'b000) begin
      errors++;
      $display("FAIL abort_idle got w=%b busy=%b done=%b, expected 0 0 0",
               bus.w_en_o, bus.busy_o, bus.done_o);
    end
    send(8'h44, 0, 0, 0);
    drain("abort");
    @(negedge clk);
    bus.arm_i   = 1'b1;
    bus.abort_i = 1'b1;
    step();
    checks++;
    if (bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_beats_arm got busy=%b, expected 0", bus.busy_o);
    end
    send(8'h45, 0, 0, 0);
    drain("abort_arm");
  endtask

  task automatic test_reset_mid();
    arm(2'b00, 8'h80, 8'h00, 10'd0, 10'd2);
    send(8'h10, 0, 0, 0);
    @(negedge clk);
    rst_n              = 1'b0;
    bus.sample_valid_i = 1'b1;
    bus.sample_data_i  = 8'h90;
    @(negedge clk);
    rst_n              = 1'b1;
    bus.sample_valid_i = 1'b0;
    checks++;
    if ({bus.w_en_o, bus.busy_o, bus.done_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid got w=%b busy=%b done=%b, expected 0 0 0",
               bus.w_en_o, bus.busy_o, bus.done_o);
    end
    send(8'h90, 0, 0, 0);
    drain("reset_mid");
  endtask

  task automatic test_gaps();
    arm(2'b00, 8'h80, 8'h00, 10'd2, 10'd2);
    send(8'h10, 1, 0, 0);
    step();
    step();
    send(8'h20, 1, 0, 0);
    step();
    send(8'h90, 1, 0, 1);
    step();
    step();
    checks++;
    if ({bus.busy_o, bus.done_o} !== 2'b10) begin
      errors++;
      $display("FAIL gaps_post_hold got busy=%b done=%b, expected 1 0", bus.busy_o, bus.done_o);
    end
    send(8'hA0, 1, 0, 0);
    send(8'hB0, 0, 0, 0);
    checks++;
    if (bus.done_o !== 1'b1) begin
      errors++;
      $display("FAIL gaps_done got %b, expected 1", bus.done_o);
    end
    drain("gaps");
  endtask

  initial begin
    bus.sample_valid_i = 1'b0;
    bus.sample_data_i  = '0;
    bus.arm_i          = 1'b0;
    bus.abort_i        = 1'b0;
    bus.mode_i         = '0;
    bus.level_i        = '0;
    bus.hyst_i         = '0;
    bus.pre_count_i    = '0;
    bus.post_count_i   = '0;
    bus.fifo_empty_i   = 1'b1;
    test_reset();
    test_rising();
    test_hysteresis();
    test_falling_either();
    test_auto();
    test_arm_blocked();
    test_abort();
    test_reset_mid();
    test_gaps();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
